// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared decode types, opcodes and ALU/result encodings for the integer core
package core_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_ctrl_e;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        alu_ctrl_e  alu_ctrl;
        logic       alu_src;
    } decode_ctrl_t;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // alt selects SUB/SRA, i.e. funct7[5] where that bit is meaningful
    function automatic alu_ctrl_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 2R1W register file, x0 hardwired to zero, optional write-to-read bypass
module regfile #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int RF_BYPASS = 1
) (
    input  logic            clk,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    localparam int AW = $clog2(REG_COUNT);

    logic [XLEN-1:0] mem [REG_COUNT];

    function automatic logic in_range(input logic [4:0] a);
        return 32'(a) < REG_COUNT;
    endfunction

    function automatic logic [XLEN-1:0] read_port(input logic [4:0] a);
        if (a == 5'd0 || !in_range(a))
            return '0;
        if (RF_BYPASS != 0 && we && waddr == a)
            return wdata;
        return mem[a[AW-1:0]];
    endfunction

    always_ff @(posedge clk) begin
        if (we && waddr != 5'd0 && in_range(waddr))
            mem[waddr[AW-1:0]] <= wdata;
    end

    always_comb rdata1 = read_port(raddr1);
    always_comb rdata2 = read_port(raddr2);

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I/E instruction decode, register read and ID/EX pipeline register
module decode_stage
    import core_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int RF_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_f,
    input  logic [31:0]     instr_f,
    input  logic [XLEN-1:0] pc_f,
    input  logic [XLEN-1:0] pc4_f,
    input  logic            stall,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            valid_e,
    output decode_ctrl_t    ctrl_e,
    output logic            illegal_e,
    output logic [4:0]      rs1_e,
    output logic [4:0]      rs2_e,
    output logic [4:0]      rd_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc4_e
);

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;

    assign opcode = instr_f[6:0];
    assign funct3 = instr_f[14:12];
    assign funct7 = instr_f[31:25];
    assign rs1    = instr_f[19:15];
    assign rs2    = instr_f[24:20];
    assign rd     = instr_f[11:7];

    logic [XLEN-1:0] rf_rd1, rf_rd2;

    regfile #(.XLEN(XLEN), .REG_COUNT(REG_COUNT), .RF_BYPASS(RF_BYPASS)) u_regfile (
        .clk    (clk),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rf_rd1),
        .rdata2 (rf_rd2),
        .we     (wb_we),
        .waddr  (wb_rd),
        .wdata  (wb_data)
    );

    logic [11:0]     imm_i_raw, imm_s_raw;
    logic [12:0]     imm_b_raw;
    logic [20:0]     imm_j_raw;
    logic [31:0]     imm_u_raw;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i_raw = instr_f[31:20];
    assign imm_s_raw = {instr_f[31:25], instr_f[11:7]};
    assign imm_b_raw = {instr_f[31], instr_f[7], instr_f[30:25], instr_f[11:8], 1'b0};
    assign imm_j_raw = {instr_f[31], instr_f[19:12], instr_f[20], instr_f[30:21], 1'b0};
    assign imm_u_raw = {instr_f[31:12], 12'h000};
    assign imm_i = XLEN'($signed(imm_i_raw));
    assign imm_s = XLEN'($signed(imm_s_raw));
    assign imm_b = XLEN'($signed(imm_b_raw));
    assign imm_j = XLEN'($signed(imm_j_raw));
    assign imm_u = XLEN'($signed(imm_u_raw));

    function automatic logic idx_oob(input logic [4:0] idx);
        return 32'(idx) >= REG_COUNT;
    endfunction

    decode_ctrl_t    ctrl_d;
    logic            illegal_d;
    logic [XLEN-1:0] imm_d;
    logic            use_rs1, use_rs2, use_rd;

    always_comb begin
        ctrl_d    = '0;
        illegal_d = 1'b0;
        imm_d     = '0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        use_rd    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.alu_ctrl = ALU_PASSB; ctrl_d.alu_src = 1'b1;
                imm_d = imm_u; use_rd = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1;
                imm_d = imm_u; use_rd = 1'b1;
            end
            OPC_JAL: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.result_src = RES_PC4; ctrl_d.jump = 1'b1;
                ctrl_d.alu_src = 1'b1; imm_d = imm_j; use_rd = 1'b1;
            end
            OPC_JALR: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.result_src = RES_PC4; ctrl_d.jump = 1'b1;
                ctrl_d.alu_src = 1'b1; imm_d = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl_d.branch = 1'b1; ctrl_d.alu_ctrl = ALU_SUB;
                imm_d = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.result_src = RES_MEM; ctrl_d.alu_src = 1'b1;
                imm_d = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
            end
            OPC_STORE: begin
                ctrl_d.mem_write = 1'b1; ctrl_d.alu_src = 1'b1;
                imm_d = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                // funct7 only carries meaning for the shift-immediate forms
                ctrl_d.reg_write = 1'b1; ctrl_d.alu_src = 1'b1;
                ctrl_d.alu_ctrl  = alu_from_funct3(funct3, funct3 == 3'd5 && funct7[5]);
                illegal_d = (funct3 == 3'd1 && funct7 != 7'h00) ||
                            (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20);
                imm_d = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
            end
            OPC_OP: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_ctrl  = alu_from_funct3(funct3, funct7[5]);
                illegal_d = !(funct7 == 7'h00 ||
                              (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)));
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            default: illegal_d = 1'b1;
        endcase
        if ((use_rs1 && idx_oob(rs1)) || (use_rs2 && idx_oob(rs2)) || (use_rd && idx_oob(rd)))
            illegal_d = 1'b1;
        if (illegal_d)
            ctrl_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_e   <= 1'b0;
            ctrl_e    <= '0;
            illegal_e <= 1'b0;
            rs1_e     <= '0;
            rs2_e     <= '0;
            rd_e      <= '0;
            rd1_e     <= '0;
            rd2_e     <= '0;
            imm_e     <= '0;
            pc_e      <= '0;
            pc4_e     <= '0;
        end else if (flush) begin
            valid_e   <= 1'b0;
            ctrl_e    <= '0;
            illegal_e <= 1'b0;
        end else if (stall) begin
            // keep held operands coherent with write-backs that land while we wait
            if (wb_we && wb_rd != 5'd0 && wb_rd == rs1_e)
                rd1_e <= wb_data;
            if (wb_we && wb_rd != 5'd0 && wb_rd == rs2_e)
                rd2_e <= wb_data;
        end else begin
            valid_e   <= valid_f;
            ctrl_e    <= valid_f ? ctrl_d : '0;
            illegal_e <= valid_f & illegal_d;
            rs1_e     <= rs1;
            rs2_e     <= rs2;
            rd_e      <= rd;
            rd1_e     <= rf_rd1;
            rd2_e     <= rf_rd2;
            imm_e     <= imm_d;
            pc_e      <= pc_f;
            pc4_e     <= pc4_f;
        end
    end

endmodule
